// File: rtl/fifo_pkt_reader_if.sv
// Bundle of the FIFO-side read port and the downstream valid/ready stream
// used by fifo_pkt_reader. The reader is the master; the FIFO/sink
// environment is the slave.
//
// Handshake rules:
//   - A FIFO read is issued in any cycle with fifo_rd_en=1. The FIFO presents
//     the word on fifo_dout after the following rising edge. fifo_rd_en is
//     never high while fifo_empty=1.
//   - A stream beat transfers on a rising edge where out_valid=1 and
//     out_ready=1. Once out_valid is high, out_data/out_last hold steady until
//     that transfer. out_valid never waits on out_ready.
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Packet reader: pulls a stream of [length header, payload words...] out of a
// synchronous FIFO, strips the headers and presents the payload as a
// valid/ready stream with an end-of-packet marker. A two-entry output buffer
// decouples FIFO read latency from downstream back-pressure.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active low
  fifo_pkt_reader_if.master    bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 err_zero_len,
  output logic                 dbg_state     // classifier state: 0=HDR, 1=PAY
);

  typedef enum logic {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } state_t;

  // Classifier state
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
  logic                  zero_hit;
  logic                  busy_q, busy_d;
  logic                  err_q;

  // Read issue tracking
  logic                  run_q;        // low until the first edge after reset
  logic                  inflight_q;   // a read was issued last cycle
  logic                  rd_en;

  // Two-entry output buffer
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  push, pop, push_last;
  logic [1:0]            occ_after_pop;
  logic [2:0]            demand;

  logic [CNT_WIDTH-1:0]  pkt_cnt_q;

  // Buffer handshake terms
  always_comb begin
    pop           = (count_q != 2'd0) && bus.out_ready;
    push          = inflight_q && (state_q == S_PAY);
    push_last     = (remaining_q == DATA_WIDTH'(1));
    occ_after_pop = count_q - {1'b0, pop};
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Read issue: a beat leaving this cycle frees its slot, which is what lets
  // the reader keep one read in flight per cycle under sustained flow.
  always_comb begin
    demand = {1'b0, occ_after_pop} + {2'b00, inflight_q};
    rd_en  = run_q && !bus.fifo_empty && (demand < 3'd2);
  end

  // Classifier next state for the word returning this cycle
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    zero_hit    = 1'b0;
    if (inflight_q) begin
      case (state_q)
        S_HDR: begin
          if (bus.fifo_dout == '0) begin
            zero_hit = 1'b1;
          end else begin
            remaining_d = bus.fifo_dout;
            state_d     = S_PAY;
          end
        end
        S_PAY: begin
          remaining_d = remaining_q - DATA_WIDTH'(1);
          if (remaining_q == DATA_WIDTH'(1)) begin
            state_d = S_HDR;
          end
        end
        default: state_d = S_HDR;
      endcase
    end
    // In a packet until the last beat has left the buffer
    busy_d = (state_d == S_PAY) || (count_d != 2'd0);
  end

  // Classifier FSM with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HDR;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      err_q       <= zero_hit;
    end
  end

  // Read issue bookkeeping; a read issued just before reset is forgotten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= rd_en;
    end
  end

  // Output buffer: circular two-entry storage with simultaneous push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= 2'b00;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.fifo_dout;
        buf_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Completed-packet counter, wrapping naturally at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else if (pop && buf_last_q[rd_ptr_q]) begin
      pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = (count_q != 2'd0);
  assign bus.out_data   = buf_data_q[rd_ptr_q];
  assign bus.out_last   = (count_q != 2'd0) && buf_last_q[rd_ptr_q];
  assign busy           = busy_q;
  assign pkt_count      = pkt_cnt_q;
  assign err_zero_len   = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a behavioural sync FIFO feeds the
// reader, a scoreboard checks every accepted beat against the expected queue.
module tb_fifo_pkt_reader;
  localparam int DW = 8;
  localparam int CW = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW)) bus();
  logic          busy;
  logic [CW-1:0] pkt_count;
  logic          err_zero_len;
  logic          dbg_state;

  fifo_pkt_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .err_zero_len (err_zero_len),
    .dbg_state    (dbg_state)
  );

  // Behavioural sync FIFO: word appears on fifo_dout after the read edge
  logic [DW-1:0] fmem [256];
  int            fwr = 0;
  int            frd = 0;
  logic          flush_req = 1'b0;
  assign bus.fifo_empty = (fwr == frd);

  always @(posedge clk) begin
    if (flush_req) begin
      frd <= fwr;
    end else if (bus.fifo_rd_en && (fwr != frd)) begin
      bus.fifo_dout <= fmem[frd];
      frd           <= frd + 1;
    end
  end

  // Scoreboard state
  logic [DW:0] exp_q [$];
  logic [DW:0] exp_w;
  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beats    = 0;
  int zero_cnt = 0;
  int beat_cyc [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat monitor: sampled on the falling edge, ahead of the transfer edge
  always @(negedge clk) begin
    cyc++;
    if (err_zero_len) zero_cnt++;
    if (rst && bus.out_valid && bus.out_ready) begin
      beat_cyc[beats] = cyc;
      beats++;
      if (exp_q.size() == 0) begin
        check("beat_unexpected", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
      end else begin
        exp_w = exp_q.pop_front();
        check("beat", {23'd0, bus.out_last, bus.out_data}, {23'd0, exp_w});
      end
    end
  end

  // Driver tasks
  task automatic push_word(input logic [DW-1:0] w);
    fmem[fwr] = w;
    fwr++;
  endtask

  task automatic push_pkt(input int len, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    push_word(DW'(len));
    for (int i = 0; i < len; i++) begin
      d = base + DW'(i);
      push_word(d);
      exp_q.push_back({(i == len - 1), d});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int k = 0;
    while (beats < target && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(tag, (beats >= target), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"},  bus.out_last, 0);
    check({tag, "_data"},  bus.out_data, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_cnt"},   pkt_count, 0);
    check({tag, "_err"},   err_zero_len, 0);
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  int b0;
  int z0;
  int k;
  logic any_act;

  initial begin
    bus.out_ready = 1'b1;

    // Reset state with a packet already waiting in the FIFO
    push_pkt(3, 8'hA1);
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_state", dbg_state, 0);

    // Packet A: 03,A1,A2,A3
    b0 = beats;
    z0 = zero_cnt;
    rst = 1'b1;
    #1;
    check("release_rd_en", bus.fifo_rd_en, 0);
    wait_beats(b0 + 3, "a_timeout");
    repeat (3) @(negedge clk);
    check("a_pkt_count", pkt_count, 1);
    check("a_busy_after", busy, 0);
    check("a_exp_empty", exp_q.size(), 0);
    check("a_back_to_back", beat_cyc[b0 + 2] - beat_cyc[b0], 2);
    check("a_no_zero_err", zero_cnt - z0, 0);

    // Packets B and C back to back
    do_reset();
    b0 = beats;
    push_pkt(2, 8'hB1);
    push_pkt(1, 8'hC1);
    wait_beats(b0 + 3, "bc_timeout");
    repeat (3) @(negedge clk);
    check("bc_pkt_count", pkt_count, 2);
    check("bc_exp_empty", exp_q.size(), 0);
    check("bc_b_gap", beat_cyc[b0 + 1] - beat_cyc[b0], 1);
    check("bc_c_gap", (beat_cyc[b0 + 2] - beat_cyc[b0 + 1]) <= 2, 1);

    // Zero-length header then 01,D1
    do_reset();
    b0 = beats;
    z0 = zero_cnt;
    push_word(8'h00);
    push_pkt(1, 8'hD1);
    wait_beats(b0 + 1, "d_timeout");
    repeat (3) @(negedge clk);
    check("d_zero_pulses", zero_cnt - z0, 1);
    check("d_pkt_count", pkt_count, 1);
    check("d_exp_empty", exp_q.size(), 0);

    // Packet E with a mid-packet stall
    do_reset();
    bus.out_ready = 1'b0;
    b0 = beats;
    push_pkt(4, 8'hE1);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("e_first_valid", bus.out_valid, 1);
    check("e_first_data", bus.out_data, 8'hE1);
    check("e_busy", busy, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("e_stall_data", bus.out_data, 8'hE2);
      check("e_stall_valid", bus.out_valid, 1);
    end
    check("e_stall_rd_en", bus.fifo_rd_en, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_beats(b0 + 4, "e_timeout");
    repeat (3) @(negedge clk);
    check("e_pkt_count", pkt_count, 1);
    check("e_exp_empty", exp_q.size(), 0);

    // Empty FIFO, then counter wrap with 8 single-beat packets
    do_reset();
    any_act = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any_act = any_act | bus.fifo_rd_en | bus.out_valid;
    end
    check("empty_idle", any_act, 0);
    b0 = beats;
    for (int i = 0; i < 7; i++) push_pkt(1, 8'h10 + 8'(i));
    wait_beats(b0 + 7, "wrap7_timeout");
    repeat (3) @(negedge clk);
    check("wrap_pkt_count_7", pkt_count, 7);
    push_pkt(1, 8'h17);
    wait_beats(b0 + 8, "wrap8_timeout");
    repeat (3) @(negedge clk);
    check("wrap_pkt_count_0", pkt_count, 0);
    check("wrap_exp_empty", exp_q.size(), 0);

    // Reset mid-packet F, then 01,G1
    do_reset();
    b0 = beats;
    push_pkt(5, 8'hF1);
    wait_beats(b0 + 2, "f_timeout");
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    exp_q.delete();
    check_reset_outputs("midrst_hold");
    b0 = beats;
    push_pkt(1, 8'hC7);
    exp_q.delete();
    exp_q.push_back({1'b1, 8'hC7});
    rst = 1'b1;
    #1;
    check("g_release_rd_en", bus.fifo_rd_en, 0);
    wait_beats(b0 + 1, "g_timeout");
    repeat (3) @(negedge clk);
    check("g_pkt_count", pkt_count, 1);
    check("g_exp_empty", exp_q.size(), 0);
    check("g_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO words and output data.
REQ-002 Parameter CNT_WIDTH, default 16: width of the packet counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 fifo_rd_en  output  1  read strobe to the upstream sync_fifo.
REQ-006 fifo_dout  input  DATA_WIDTH  FIFO read data; valid on the rising edge after the fifo_rd_en cycle.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 out_data  output  DATA_WIDTH  payload byte.
REQ-009 out_valid  output  1  out_data/out_last valid.
REQ-010 out_last  output  1  final payload byte of a packet.
REQ-011 out_ready  input  1  downstream accepts the beat when out_valid=1 and out_ready=1.
REQ-012 busy  output  1  high while inside a packet (between header accept and last-beat handshake).
REQ-013 pkt_count  output  CNT_WIDTH  completed packets since reset.
REQ-014 err_zero_len  output  1  one-cycle pulse when a header of value 0 is consumed.

Function
REQ-015 Stream format in the FIFO: one header word L (payload length, 1..2^DATA_WIDTH-1), then L payload words, repeated.
REQ-016 Read issue: fifo_rd_en = !fifo_empty and (buffered beats + reads in flight) < 2; never asserted while fifo_empty=1.
REQ-017 Each returned word is classified one cycle after its fifo_rd_en cycle, in order.
REQ-018 Classifier states: HDR, PAY; HDR after reset.
REQ-019 HDR, word L != 0: load remaining=L, go to PAY; the word is not output.
REQ-020 HDR, word L == 0: pulse err_zero_len, discard, stay in HDR.
REQ-021 PAY: push word into the 2-entry output buffer with last flag = (remaining==1); decrement remaining; remaining reaching 0 -> HDR.
REQ-022 Output buffer is FIFO-ordered, 2 entries; a push and a pop in the same cycle are both honoured; no overflow by construction of REQ-016.
REQ-023 out_valid = buffer non-empty; out_data/out_last from the head entry; held stable while out_valid=1 and out_ready=0.
REQ-024 pkt_count increments by 1 on each handshake with out_last=1; wraps from all-ones to 0.
REQ-025 busy rises on the cycle after a nonzero header is classified and falls on the cycle after the out_last handshake.
REQ-026 Sustained throughput: 1 beat/cycle when FIFO non-empty and out_ready held high, after the initial 2-cycle fill.
REQ-027 Back-to-back packets: the next header is processed without an idle cycle on the FIFO side.

Reset
REQ-028 rst=0 asynchronously forces: fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, busy=0, pkt_count=0, err_zero_len=0, classifier=HDR, buffer and in-flight count cleared.
REQ-029 Reset mid-packet discards buffered and in-flight words; after release the next word read is treated as a header.
REQ-030 Outputs are stable at reset values until the first rising edge after rst returns to 1.

Verification
REQ-031 FIFO holds 03,A1,A2,A3; out_ready=1 -> beats A1,A2,A3, out_last only on A3, pkt_count=1, busy low afterwards.
REQ-032 FIFO holds 02,B1,B2,01,C1 -> B1,B2(last),C1(last) in order, no gaps beyond fill, pkt_count=2.
REQ-033 FIFO holds 00,01,D1 -> err_zero_len pulses once, single beat D1 with out_last=1, pkt_count=1.
REQ-034 Packet 04,E1..E4, out_ready low for 5 cycles mid-packet -> out_data stays at the stalled beat, fifo_rd_en drops after 2 buffered, no loss or duplication.
REQ-035 FIFO empty throughout -> fifo_rd_en never asserted, out_valid=0; then 8 packets of length 1 with pkt_count preset near wrap (CNT_WIDTH=3) -> pkt_count reads 0 after the 8th.
REQ-036 Assert rst=0 after the second beat of 05,F1..F5 -> all outputs at reset values immediately; after release, FIFO contents 01,G1 -> single beat G1 with out_last=1.
